// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 iterative RV32M/RV64M multiply/divide unit.
// Ports: clock/reset_n/flush; in_valid/in_ready/op/inA/inB; out_valid/out_ready/out/zero.
module alu_muldiv_iter #(
  parameter  int N  = 32,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t         state_q, state_d;
  logic [2:0]     op_q;
  logic [N-1:0]   opnd_q;
  logic [2*N-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;
  logic           neg_r_q;
  logic [N-1:0]   out_q;

  logic           accept;
  logic           sgn_a, sgn_b;
  logic           sa, sb;
  logic [N-1:0]   a_mag, b_mag;
  logic           is_div;
  logic           b_zero, ovf, special;
  logic [N-1:0]   spec_res;

  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_nxt;
  logic [N:0]     rem_sh, diff;
  logic           ge;
  logic [2*N-1:0] div_nxt;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;
  logic [N-1:0]   q_res, r_res;
  logic [N-1:0]   calc_res;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == DONE) & ~flush;
  assign out       = out_q;
  assign zero      = out_valid & (out_q == '0);

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op)
      3'd1, 3'd4, 3'd6: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'd2:    sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign sa     = sgn_a & inA[N-1];
  assign sb     = sgn_b & inB[N-1];
  assign a_mag  = sa ? -inA : inA;
  assign b_mag  = sb ? -inB : inB;
  assign is_div = op[2];

  // Divide-by-zero and signed overflow bypass the iteration.
  assign b_zero  = (inB == '0);
  assign ovf     = ~op[0] & (inA == MIN_NEG) & (inB == '1);
  assign special = is_div & (b_zero | ovf);

  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = op[1] ? inA : '1;
    else
      spec_res = op[1] ? '0 : inA;
  end

  // Shift-add step: add multiplicand into the high half, shift right.
  assign mul_sum = {1'b0, acc_q[2*N-1:N]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[N-1:1]};

  // Restoring step: rem:dividend shifts left, quotient bit enters at bit 0.
  assign rem_sh  = {acc_q[2*N-1:N], acc_q[N-1]};
  assign diff    = rem_sh - {1'b0, opnd_q};
  assign ge      = ~diff[N];
  assign div_nxt = {ge ? diff[N-1:0] : rem_sh[N-1:0],
                    acc_q[N-2:0], ge};

  assign prod  = neg_q ? -mul_nxt : mul_nxt;
  assign quo   = div_nxt[N-1:0];
  assign rem   = div_nxt[2*N-1:N];
  assign q_res = neg_q ? -quo : quo;
  assign r_res = neg_r_q ? -rem : rem;

  always_comb begin
    calc_res = '0;
    if (op_q[2])
      calc_res = op_q[1] ? r_res : q_res;
    else if (op_q[1:0] == 2'd0)
      calc_res = prod[N-1:0];
    else
      calc_res = prod[2*N-1:N];
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = special ? DONE : CALC;
        CALC: if (cnt_q == CW'(1)) state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      op_q    <= op;
      cnt_q   <= CW'(N);
      neg_q   <= sa ^ sb;
      neg_r_q <= sa;
      if (is_div) begin
        opnd_q <= b_mag;
        acc_q  <= {{N{1'b0}}, a_mag};
      end else begin
        opnd_q <= a_mag;
        acc_q  <= {{N{1'b0}}, b_mag};
      end
      if (special) out_q <= spec_res;
    end else if (state_q == CALC && !flush) begin
      acc_q <= op_q[2] ? div_nxt : mul_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) out_q <= calc_res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// tb_alu_muldiv_iter: scoreboard bench for alu_muldiv_iter (N=32).
// Random and directed ops are checked against an arithmetic reference model.
module tb_alu_muldiv_iter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [N-1:0] inA = '0;
  logic [N-1:0] inB = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] dut_out;
  logic         zero;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;
  int rise_cyc = 0;
  bit prev_valid = 1'b0;

  typedef struct {
    logic [N-1:0] val;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv_iter #(.N(N)) dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .inA      (inA),
    .inB      (inB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dut_out),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else            out_ready = ready_force;
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic logic [N-1:0] model(input logic [2:0] o,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o,
                                   input logic [N-1:0] a,
                                   input logic [N-1:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return N + 1;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [N-1:0] a,
                       input logic [N-1:0] b, input bit push);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      timeout("issue_in_ready");
      return;
    end
    op = o;
    inA = a;
    inB = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7));
    inA = $urandom;
    inB = $urandom;
    if (push) begin
      e.val = model(o, a, b);
      e.acc = cyc;
      e.lat = model_lat(o, a, b);
      e.name = $sformatf("op%0d_%h_%h", o, a, b);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  function automatic logic [N-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got out %h, expected no result",
                   dut_out);
        end else if (!out_ready) begin
          check({exp_q[0].name, "_hold"}, 64'(dut_out), 64'(exp_q[0].val));
          check("in_ready_in_done", 64'(in_ready), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(e.name, 64'(dut_out), 64'(e.val));
          check({e.name, "_zero"}, 64'(zero), 64'(e.val == '0));
          check({e.name, "_lat"}, 64'(rise_cyc - e.acc + 1), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    int k;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(dut_out), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 1'b1);
    issue(3'd7, 32'd5, 32'd0, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Backpressure: result held while out_ready is low.
    ready_force = 1'b0;
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) timeout("hold_wait");
    repeat (5) @(negedge clk);
    ready_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("after_hs_in_ready", 64'(in_ready), 64'd1);
    check("after_hs_out_valid", 64'(out_valid), 64'd0);
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    drain();

    // Flush in CALC cycle 10.
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    op = 3'd0;
    @(posedge clk);
    #2;
    flush = 1'b0;
    in_valid = 1'b0;
    check("idle_flush_no_accept", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);

    // Reset mid-CALC.
    issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(dut_out), 64'd0);
    check("midrst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 1'b1);
    drain();

    // Random ops with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
